lvds_rx: RTL and testbench

//  Source-synchronous 2:1 DDR deserializer for the MIPI/LVDS receive front end.

---
 rtl/lvds_rx.sv | 68 ++++++
 tb/tb_lvds_rx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lvds_rx.sv
// 2:1 DDR deserializer for the LVDS receive front end with a lock counter.
// Lane ch lands on rx_out[ch] (rising-edge bit) and rx_out[ch+NUM_CH] (falling-edge bit).
module lvds_rx #(
  parameter int NUM_CH      = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  rx_inclock,
  input  logic                  rstn,
  input  logic [NUM_CH-1:0]     rx_in,
  output logic [2*NUM_CH-1:0]   rx_out,
  output logic                  rx_outclock,
  output logic                  rx_locked
);

  localparam int             CW        = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0]  LOCK_LOAD = CW'(LOCK_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] fall_q;
  logic [CW-1:0]     lock_cnt;
  logic              lock_tc;
  logic              locked_nxt;

  assign rx_outclock = rx_inclock;

  // Down-counter reaches terminal count on the LOCK_CYCLES-th edge after release.
  assign lock_tc    = (lock_cnt == CNT_ONE);
  assign locked_nxt = rx_locked | lock_tc;

  always_ff @(posedge rx_inclock) begin
    if (!rstn) begin
      rise_q <= '0;
    end else begin
      rise_q <= rx_in;
    end
  end

  always_ff @(negedge rx_inclock) begin
    if (!rstn) begin
      fall_q <= '0;
    end else begin
      fall_q <= rx_in;
    end
  end

  always_ff @(posedge rx_inclock) begin
    if (!rstn) begin
      lock_cnt  <= LOCK_LOAD;
      rx_locked <= 1'b0;
    end else begin
      if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - CNT_ONE;
      end
      rx_locked <= locked_nxt;
    end
  end

  // Gate with the next lock state so rx_out carries data exactly when rx_locked is high.
  always_ff @(posedge rx_inclock) begin
    if (!rstn || !locked_nxt) begin
      rx_out <= '0;
    end else begin
      rx_out <= {fall_q, rise_q};
    end
  end

endmodule

// File: tb/tb_lvds_rx.sv
// Self-checking bench for lvds_rx: directed vectors, multi-cycle sequences and
// randomized traffic compared against a cycle-level reference model.
module tb_lvds_rx;

  localparam int NUM_CH = 4;
  localparam int LOCK   = 16;

  logic                 clk;
  logic                 rstn;
  logic [NUM_CH-1:0]    rx_in;
  logic [2*NUM_CH-1:0]  rx_out;
  logic                 rx_outclock;
  logic                 rx_locked;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int                 m_edges;
  logic               m_locked;
  logic [7:0]         m_out;
  logic [3:0]         m_rise;
  logic [3:0]         m_fall;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [6];
  logic [7:0] seq_exp [4];
  logic [3:0] seq_r [4];
  logic [3:0] seq_f [4];

  lvds_rx #(.NUM_CH(NUM_CH), .LOCK_CYCLES(LOCK)) dut (
    .rx_inclock (clk),
    .rstn       (rstn),
    .rx_in      (rx_in),
    .rx_out     (rx_out),
    .rx_outclock(rx_outclock),
    .rx_locked  (rx_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full clock cycle: r is sampled at the rising edge, f at the falling edge.
  // Entered and left 1 time unit after a falling edge.
  task automatic step(input logic [3:0] r, input logic [3:0] f, input logic rs, input string tag);
    rx_in = r;
    rstn  = rs;
    @(posedge clk); #1;
    if (!rs) begin
      m_edges  = 0;
      m_locked = 1'b0;
      m_out    = 8'h00;
      m_rise   = 4'h0;
    end else begin
      if (m_edges < LOCK) m_edges++;
      m_locked = (m_edges >= LOCK);
      m_out    = m_locked ? {m_fall, m_rise} : 8'h00;
      m_rise   = r;
    end
    check({tag, "_out"}, rx_out, m_out);
    check({tag, "_lock"}, {7'd0, rx_locked}, {7'd0, m_locked});
    check({tag, "_oclk_hi"}, {7'd0, rx_outclock}, 8'd1);
    rx_in = f;
    @(negedge clk); #1;
    m_fall = rs ? f : 4'h0;
  endtask

  initial begin
    m_edges = 0; m_locked = 1'b0; m_out = 8'h00; m_rise = 4'h0; m_fall = 4'h0;
    rstn  = 1'b0;
    rx_in = 4'h0;

    tbl[0] = '{rise: 4'hF, fall: 4'hF, exp: 8'hFF};
    tbl[1] = '{rise: 4'hF, fall: 4'h0, exp: 8'h0F};
    tbl[2] = '{rise: 4'h0, fall: 4'hF, exp: 8'hF0};
    tbl[3] = '{rise: 4'h2, fall: 4'h8, exp: 8'h82};
    tbl[4] = '{rise: 4'h0, fall: 4'h0, exp: 8'h00};
    tbl[5] = '{rise: 4'hA, fall: 4'h5, exp: 8'h5A};

    seq_r[0] = 4'hF; seq_f[0] = 4'h0; seq_exp[0] = 8'h0F;
    seq_r[1] = 4'hF; seq_f[1] = 4'hF; seq_exp[1] = 8'hFF;
    seq_r[2] = 4'hF; seq_f[2] = 4'h0; seq_exp[2] = 8'h0F;
    seq_r[3] = 4'h0; seq_f[3] = 4'h0; seq_exp[3] = 8'h00;

    @(negedge clk); #1;

    // reset held for 3 cycles with active data on the lanes
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 4'hF, 1'b0, "rst");
      check("rst_out_zero", rx_out, 8'h00);
      check("rst_lock_zero", {7'd0, rx_locked}, 8'd0);
    end
    check("oclk_lo", {7'd0, rx_outclock}, 8'd0);

    // lock asserts exactly on the 16th rising edge after release
    for (int i = 1; i <= LOCK; i++) begin
      step(4'hF, 4'hF, 1'b1, "lock");
      check("lock_edge", {7'd0, rx_locked}, {7'd0, (i == LOCK)});
      if (i < LOCK) check("prelock_out_zero", rx_out, 8'h00);
    end
    check("lock_first_word", rx_out, 8'hFF);

    // directed patterns: each held two cycles, the word of the first cycle is checked
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].rise, tbl[i].fall, 1'b1, "tbl_a");
      step(tbl[i].rise, tbl[i].fall, 1'b1, "tbl_b");
      check($sformatf("tbl%0d", i), rx_out, tbl[i].exp);
    end

    // half-cycle sequence 1,0,1,1,1,0,0,0 on all lanes
    for (int k = 0; k < 9; k++) begin
      step(seq_r[k % 4], seq_f[k % 4], 1'b1, "seq");
      if (k > 0) check($sformatf("seq%0d", k), rx_out, seq_exp[(k - 1) % 4]);
    end

    // one-cycle reset pulse while streaming all ones
    step(4'hF, 4'hF, 1'b0, "mid");
    check("mid_rst_out", rx_out, 8'h00);
    check("mid_rst_lock", {7'd0, rx_locked}, 8'd0);
    for (int i = 1; i <= LOCK; i++) begin
      step(4'hF, 4'hF, 1'b1, "relock");
      check("relock_edge", {7'd0, rx_locked}, {7'd0, (i == LOCK)});
    end
    check("relock_data", rx_out, 8'hFF);

    // randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 39) != 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
